merge_layer_nxn: RTL and testbench

- Parametrised successor of the 2+2 lower merge layer.
- Merges two pre-sorted lists of N elements each into one sorted stream of 2N elements, emitted one per clock.
- Each element carries a label tag, so KNN distances keep their class/index through the sort.
- Sort direction is selectable per operation; instances cascade (N=2,4,8,...) to build the full merge-sort tree.

---
 rtl/merge_layer_nxn.sv | 103 ++++++++++
 tb/tb_merge_layer_nxn.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_layer_nxn.sv
// merge_layer_nxn: merges two pre-sorted N-element labelled lists into one sorted stream, one element per clock
//   clk, rst              : clock, synchronous active-high reset
//   load, descend         : start request (accepted when idle), sort direction captured with load
//   data_a/b, label_a/b   : packed input lists, element 0 first in sort order
//   busy, update, done    : operation active, output valid, final-element pulse
//   sorted_data/label     : merged key stream and its tag
module merge_layer_nxn #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 4,
    parameter int N           = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     descend,
    input  logic [N*DATA_WIDTH-1:0]  data_a,
    input  logic [N*DATA_WIDTH-1:0]  data_b,
    input  logic [N*LABEL_WIDTH-1:0] label_a,
    input  logic [N*LABEL_WIDTH-1:0] label_b,
    output logic                     busy,
    output logic                     update,
    output logic [DATA_WIDTH-1:0]    sorted_data,
    output logic [LABEL_WIDTH-1:0]   sorted_label,
    output logic                     done
);
    localparam int PW = $clog2(N + 1);
    localparam int CW = $clog2(2 * N);
    localparam logic [PW-1:0] PEND = PW'(N);
    localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

    typedef enum logic {IDLE, MERGE} state_t;

    state_t                   state;
    logic [N*DATA_WIDTH-1:0]  a_q, b_q;
    logic [N*LABEL_WIDTH-1:0] la_q, lb_q;
    logic                     desc_q;
    logic [PW-1:0]            ptr_a, ptr_b;
    logic [CW-1:0]            cnt;
    logic                     take_a;

    // Lists are kept as shift registers: the head of each list is always in the low slot,
    // pointers only track how many elements have been consumed.
    always_comb
        take_a = (ptr_a == PEND) ? 1'b0 :
                 (ptr_b == PEND) ? 1'b1 :
                 desc_q ? (a_q[DATA_WIDTH-1:0] >= b_q[DATA_WIDTH-1:0])
                        : (a_q[DATA_WIDTH-1:0] <= b_q[DATA_WIDTH-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            update       <= 1'b0;
            done         <= 1'b0;
            sorted_data  <= '0;
            sorted_label <= '0;
            ptr_a        <= '0;
            ptr_b        <= '0;
            cnt          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            la_q         <= '0;
            lb_q         <= '0;
            desc_q       <= 1'b0;
        end else begin
            update <= 1'b0;
            done   <= 1'b0;
            if (state == IDLE) begin
                if (load) begin
                    a_q    <= data_a;
                    b_q    <= data_b;
                    la_q   <= label_a;
                    lb_q   <= label_b;
                    desc_q <= descend;
                    ptr_a  <= '0;
                    ptr_b  <= '0;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    state  <= MERGE;
                end
            end else begin
                update       <= 1'b1;
                sorted_data  <= take_a ? a_q[DATA_WIDTH-1:0] : b_q[DATA_WIDTH-1:0];
                sorted_label <= take_a ? la_q[LABEL_WIDTH-1:0] : lb_q[LABEL_WIDTH-1:0];
                if (take_a) begin
                    a_q   <= a_q >> DATA_WIDTH;
                    la_q  <= la_q >> LABEL_WIDTH;
                    ptr_a <= ptr_a + PW'(1);
                end else begin
                    b_q   <= b_q >> DATA_WIDTH;
                    lb_q  <= lb_q >> LABEL_WIDTH;
                    ptr_b <= ptr_b + PW'(1);
                end
                cnt <= cnt + CW'(1);
                if (cnt == LAST) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_merge_layer_nxn.sv
// tb_merge_layer_nxn: directed scoreboard bench for merge_layer_nxn at N=4, N=1 and N=3
module tb_merge_layer_nxn;
    logic clk = 1'b0, rst = 1'b1, desc = 1'b0;
    logic ld4 = 1'b0, ld1 = 1'b0, ld3 = 1'b0;
    logic [31:0] da4 = '0, db4 = '0;
    logic [15:0] la4 = '0, lb4 = '0;
    logic [7:0]  da1 = '0, db1 = '0;
    logic [3:0]  la1 = '0, lb1 = '0;
    logic [23:0] da3 = '0, db3 = '0;
    logic [11:0] la3 = '0, lb3 = '0;
    logic busy4, upd4, done4, busy1, upd1, done1, busy3, upd3, done3;
    logic [7:0] sd4, sd1, sd3;
    logic [3:0] sl4, sl1, sl3;

    always #5 clk = ~clk;

    merge_layer_nxn #(.DATA_WIDTH(8), .LABEL_WIDTH(4), .N(4)) dut4 (
        .clk(clk), .rst(rst), .load(ld4), .descend(desc),
        .data_a(da4), .data_b(db4), .label_a(la4), .label_b(lb4),
        .busy(busy4), .update(upd4), .sorted_data(sd4), .sorted_label(sl4), .done(done4));
    merge_layer_nxn #(.DATA_WIDTH(8), .LABEL_WIDTH(4), .N(1)) dut1 (
        .clk(clk), .rst(rst), .load(ld1), .descend(desc),
        .data_a(da1), .data_b(db1), .label_a(la1), .label_b(lb1),
        .busy(busy1), .update(upd1), .sorted_data(sd1), .sorted_label(sl1), .done(done1));
    merge_layer_nxn #(.DATA_WIDTH(8), .LABEL_WIDTH(4), .N(3)) dut3 (
        .clk(clk), .rst(rst), .load(ld3), .descend(desc),
        .data_a(da3), .data_b(db3), .label_a(la3), .label_b(lb3),
        .busy(busy3), .update(upd3), .sorted_data(sd3), .sorted_label(sl3), .done(done3));

    typedef struct packed {logic [7:0] d; logic [3:0] l; logic dn;} exp_t;
    exp_t q4[$], q1[$], q3[$];
    exp_t e4, e1, e3;
    int total = 0, bad = 0;
    int nu1 = 0, nd1 = 0, nu3 = 0, nd3 = 0;
    logic [7:0] ka[4], kb[4];
    logic [3:0] lka[4], lkb[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_in();
        for (int i = 0; i < 4; i++) begin
            da4[i*8+:8] = ka[i];
            db4[i*8+:8] = kb[i];
            la4[i*4+:4] = lka[i];
            lb4[i*4+:4] = lkb[i];
            if (i < 3) begin
                da3[i*8+:8] = ka[i];
                db3[i*8+:8] = kb[i];
                la3[i*4+:4] = lka[i];
                lb3[i*4+:4] = lkb[i];
            end
        end
        da1 = ka[0];
        db1 = kb[0];
        la1 = lka[0];
        lb1 = lkb[0];
    endtask

    // Reference: stable insertion sort of A-then-B, so equal keys keep A before B.
    task automatic push_exp(input int n);
        logic [7:0] k[8];
        logic [3:0] l[8];
        logic [7:0] tk;
        logic [3:0] tl;
        int j;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            k[i] = ka[i];
            l[i] = lka[i];
            k[n+i] = kb[i];
            l[n+i] = lkb[i];
        end
        for (int i = 1; i < 2 * n; i++) begin
            j = i;
            while (j > 0 && (desc ? k[j] > k[j-1] : k[j] < k[j-1])) begin
                tk = k[j]; k[j] = k[j-1]; k[j-1] = tk;
                tl = l[j]; l[j] = l[j-1]; l[j-1] = tl;
                j--;
            end
        end
        for (int i = 0; i < 2 * n; i++) begin
            e.d = k[i];
            e.l = l[i];
            e.dn = (i == 2 * n - 1);
            if (n == 4) q4.push_back(e);
            else if (n == 1) q1.push_back(e);
            else q3.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (upd4) begin
            chk("n4_unexpected_update", 32'(q4.size() != 0), 1);
            if (q4.size() != 0) begin
                e4 = q4.pop_front();
                chk("n4_stream", 32'({sd4, sl4, done4}), 32'({e4.d, e4.l, e4.dn}));
            end
        end else chk("n4_done_without_update", 32'(done4), 0);
    end

    always @(negedge clk) begin
        if (upd1) begin
            nu1++;
            chk("n1_unexpected_update", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("n1_stream", 32'({sd1, sl1, done1}), 32'({e1.d, e1.l, e1.dn}));
            end
        end
        if (done1) nd1++;
    end

    always @(negedge clk) begin
        if (upd3) begin
            nu3++;
            chk("n3_unexpected_update", 32'(q3.size() != 0), 1);
            if (q3.size() != 0) begin
                e3 = q3.pop_front();
                chk("n3_stream", 32'({sd3, sl3, done3}), 32'({e3.d, e3.l, e3.dn}));
            end
        end
        if (done3) nd3++;
    end

    task automatic launch4();
        set_in();
        push_exp(4);
        ld4 = 1'b1;
        @(posedge clk);
        #1 ld4 = 1'b0;
    endtask

    // Walks cycles t+1..t+9 of an N=4 operation; optionally re-loads while busy or resets mid-stream.
    task automatic watch4(input int ign_at, input int rst_at);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("n4_busy_k%0d", k), 32'(busy4), 1);
            chk($sformatf("n4_update_k%0d", k), 32'(upd4), 32'(k >= 2));
            if (k == ign_at) begin
                ld4 = 1'b1;
                da4 = ~da4;
                db4 = ~db4;
                la4 = ~la4;
            end
            if (k == ign_at + 1) ld4 = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                q4.delete();
                @(negedge clk);
                chk("rst_mid_busy", 32'(busy4), 0);
                chk("rst_mid_update", 32'(upd4), 0);
                chk("rst_mid_done", 32'(done4), 0);
                chk("rst_mid_data", 32'(sd4), 0);
                chk("rst_mid_label", 32'(sl4), 0);
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_quiet", 32'(upd4 | busy4), 0);
                end
                return;
            end
        end
        @(negedge clk);
        chk("n4_busy_k9", 32'(busy4), 0);
        chk("n4_update_k9", 32'(upd4), 1);
        chk("n4_done_k9", 32'(done4), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy4), 0);
        chk("reset_update", 32'(upd4), 0);
        chk("reset_done", 32'(done4), 0);
        chk("reset_data", 32'(sd4), 0);
        chk("reset_label", 32'(sl4), 0);

        ka = '{3, 9, 20, 40}; kb = '{1, 9, 15, 50};
        lka = '{1, 2, 3, 4}; lkb = '{5, 6, 7, 8};
        desc = 1'b0;
        launch4();
        watch4(3, 0);

        ka = '{200, 100, 50, 0}; kb = '{255, 100, 10, 5};
        desc = 1'b1;
        launch4();
        watch4(0, 0);

        ka = '{1, 2, 3, 4}; kb = '{10, 11, 12, 13};
        desc = 1'b0;
        launch4();
        watch4(0, 0);

        ka = '{10, 11, 12, 13}; kb = '{1, 2, 3, 4};
        launch4();
        watch4(0, 0);

        ka = '{255, 255, 255, 255}; kb = '{255, 255, 255, 255};
        launch4();
        watch4(0, 0);

        ka = '{3, 9, 20, 40}; kb = '{1, 9, 15, 50};
        launch4();
        watch4(0, 5);

        launch4();
        watch4(0, 0);
        @(negedge clk);
        chk("n4_idle_after", 32'(upd4 | busy4), 0);

        nu1 = 0; nd1 = 0;
        set_in();
        push_exp(1);
        ld1 = 1'b1;
        @(posedge clk);
        #1 ld1 = 1'b0;
        for (int c = 0; c < 20 && q1.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("n1_drained", 32'(q1.size()), 0);
        chk("n1_updates", 32'(nu1), 2);
        chk("n1_dones", 32'(nd1), 1);

        nu3 = 0; nd3 = 0;
        set_in();
        push_exp(3);
        ld3 = 1'b1;
        @(posedge clk);
        #1 ld3 = 1'b0;
        for (int c = 0; c < 40 && q3.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("n3_drained", 32'(q3.size()), 0);
        chk("n3_updates", 32'(nu3), 6);
        chk("n3_dones", 32'(nd3), 1);
        chk("n4_drained", 32'(q4.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
